// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: FSM state codes, strobe/word geometry and the
// region hit decode. The core-side bus master uses this package too.
package dbus_pkg;

    localparam int STRB_W     = 4;
    localparam int BYTE_W     = 8;
    localparam int WORD_W     = STRB_W * BYTE_W;
    localparam int WORD_BYTES = STRB_W;

    // state | meaning
    // IDLE  | waiting for busReq, latches the request when it arrives
    // WAIT  | counting down programmed wait states
    // RESP  | one-cycle busReady (+busErr on miss), write commits at its end
    // INIT  | post-reset RAM clear sweep (DBUS_INIT_CLEAR_EN builds only)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_INIT = 2'd3;

    // Region hit: every address bit above the word index must match the base.
    // aw is the word-index width, so the region spans 4*2**aw bytes.
    function automatic logic dbus_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int          aw);
        logic [31:0] mask;
        mask = ~((32'd4 << aw) - 32'd1);
        return ((addr ^ base) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/dbus_bytewe_ram.sv
// Word-organised synchronous RAM, 2**ADDR_WIDTH x 32, with per-byte write
// enables and a registered read port. The read register is the bus read-data
// register: it can be loaded with zero (rclr) and is cleared by reset, while
// the array itself is never reset.
module dbus_bytewe_ram
    import dbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [STRB_W-1:0]     we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

    // byte-lane writes into the array
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (we[i]) begin
                mem[waddr][BYTE_W*i +: BYTE_W] <= wdata[BYTE_W*i +: BYTE_W];
            end
        end
    end

    // registered read port; holds until the next read or clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rclr ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/dbus_ram_responder.sv
// Data-bus RAM responder. Accepts one read/write at a time, inserts
// WAIT_STATES wait cycles and answers with a one-cycle busReady, flagged by
// busErr when the address falls outside the BASE_ADDR region.
// Optional build macro: DBUS_INIT_CLEAR_EN -- adds a post-reset sweep that
// zeroes every RAM word before the first request is accepted.
module dbus_ram_responder
    import dbus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [3:0]  busStrb,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);

    localparam logic       NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef DBUS_INIT_CLEAR_EN
    localparam logic [1:0]            RESET_STATE = ST_INIT;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST   = '1;
`else
    localparam logic [1:0]            RESET_STATE = ST_IDLE;
`endif

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic                  lat_we;
    logic                  lat_hit;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_wdata;
    logic [STRB_W-1:0]     lat_strb;
`ifdef DBUS_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] init_idx;
`endif

    logic                  req_hit;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  rd_we;
    logic                  rd_hit;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  enter_resp;
    logic                  ram_re;
    logic                  ram_rclr;
    logic [STRB_W-1:0]     ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [31:0]           ram_wdata;

    assign req_hit = dbus_hit(busAddr, BASE_ADDR, ADDR_WIDTH);
    assign req_idx = busAddr[ADDR_WIDTH+1:2];

    // With no wait states RESP is entered straight from IDLE, so the read
    // has to be issued from the live bus rather than the latched copy.
    always_comb begin
        rd_we  = lat_we;
        rd_hit = lat_hit;
        rd_idx = lat_idx;
        if (state == ST_IDLE) begin
            rd_we  = busWe;
            rd_hit = req_hit;
            rd_idx = req_idx;
        end
    end

    assign enter_resp = ((state == ST_IDLE) && busReq && NO_WAIT) ||
                        ((state == ST_WAIT) && (wait_cnt == 4'd0));
    assign ram_re     = enter_resp && !rd_we;
    assign ram_rclr   = !rd_hit;

    // write port: committed writes at the end of RESP, or the clear sweep
    always_comb begin
        ram_waddr = lat_idx;
        ram_wdata = lat_wdata;
        ram_we    = (state == ST_RESP && lat_we && lat_hit) ? lat_strb : '0;
`ifdef DBUS_INIT_CLEAR_EN
        if (state == ST_INIT) begin
            ram_waddr = init_idx;
            ram_wdata = '0;
            ram_we    = '1;
        end
`endif
    end

    // transfer FSM, wait counter, request latches and response flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RESET_STATE;
            wait_cnt  <= 4'd0;
            busReady  <= 1'b0;
            busErr    <= 1'b0;
            lat_we    <= 1'b0;
            lat_hit   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_strb  <= '0;
`ifdef DBUS_INIT_CLEAR_EN
            init_idx  <= '0;
`endif
        end else begin
            busReady <= 1'b0;
            busErr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (busReq) begin
                        lat_we    <= busWe;
                        lat_hit   <= req_hit;
                        lat_idx   <= req_idx;
                        lat_wdata <= busWData;
                        lat_strb  <= busStrb;
                        if (NO_WAIT) begin
                            state    <= ST_RESP;
                            busReady <= 1'b1;
                            busErr   <= !req_hit;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= ST_RESP;
                        busReady <= 1'b1;
                        busErr   <= !lat_hit;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
`ifdef DBUS_INIT_CLEAR_EN
                ST_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == INIT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dbus_bytewe_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rclr  (ram_rclr),
        .raddr (rd_idx),
        .rdata (busRData)
    );

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Bench for dbus_ram_responder: three instances (1, 0 and 3 wait states)
// share clock and reset and are driven one at a time through a bus task.
// Expected results come from a word-array model of each RAM region.
module tb_dbus_ram_responder;

    localparam int          AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          NDUT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [NDUT];
    logic        we    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic [3:0]  strb  [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ready [NDUT];
    logic        err   [NDUT];

    logic [31:0] model_mem   [NDUT][DEPTH];
    logic [31:0] model_rdata [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        dbus_ram_responder #(
            .ADDR_WIDTH (AW),
            .WAIT_STATES(WS),
            .BASE_ADDR  (BASE)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .busReq  (req[g]),
            .busWe   (we[g]),
            .busAddr (addr[g]),
            .busWData(wdata[g]),
            .busStrb (strb[g]),
            .busRData(rdata[g]),
            .busReady(ready[g]),
            .busErr  (err[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check_eq(input int k, input string tag,
                            input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", tag, k, got, exp);
        end
    endtask

    // reset effect on the model: read-data registers clear, RAM cleared only
    // when the clear sweep is built in
    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            model_rdata[k] = 32'd0;
`ifdef DBUS_INIT_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) model_mem[k][i] = 32'd0;
`endif
        end
    endtask

    // one bus transfer; lat = negedges from request until busReady is seen
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int budget,
                        output int lat, output logic e, output logic [31:0] rd);
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; strb[k] = s;
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (ready[k]) begin
                lat = c;
                break;
            end
        end
        e  = err[k];
        rd = rdata[k];
        req[k] = 1'b0;
        check_eq(k, "ready_seen", {31'd0, lat != 0}, 32'd1);
    endtask

    task automatic do_op(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int          lat;
        logic        e;
        logic [31:0] rd;
        logic        hit;
        int          idx;
        hit = (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
        idx = int'((a - BASE) / 32'd4);
        xfer(k, w, a, d, s, 64, lat, e, rd);
        check_eq(k, "latency", 32'(lat), 32'(ws_of(k) + 1));
        check_eq(k, "err", {31'd0, e}, {31'd0, !hit});
        if (!w) begin
            model_rdata[k] = hit ? model_mem[k][idx] : 32'd0;
        end else if (hit) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model_mem[k][idx][8*i +: 8] = d[8*i +: 8];
        end
        check_eq(k, w ? "rdata_hold" : "rdata", rd, model_rdata[k]);
    endtask

    // write then read with busReq held high across both transfers
    task automatic b2b(input int k, input logic [31:0] d0);
        int gap;
        int first;
        int pulses;
        @(negedge clk);
        req[k] = 1'b1; we[k] = 1'b1; addr[k] = BASE + 32'h14; wdata[k] = d0; strb[k] = 4'hF;
        first = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (ready[k]) begin
                first = c;
                break;
            end
        end
        check_eq(k, "b2b_first_lat", 32'(first), 32'(ws_of(k) + 1));
        model_mem[k][5] = d0;
        we[k] = 1'b0;
        gap = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (ready[k]) begin
                gap = c;
                break;
            end
        end
        check_eq(k, "b2b_gap", 32'(gap), 32'(ws_of(k) + 2));
        check_eq(k, "b2b_err", {31'd0, err[k]}, 32'd0);
        check_eq(k, "b2b_rdata", rdata[k], d0);
        model_rdata[k] = d0;
        req[k] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ready[k]) pulses++;
        end
        check_eq(k, "b2b_extra_ready", 32'(pulses), 32'd0);
    endtask

    // reset while a write to word 3 sits in WAIT
    task automatic abort_write(input int k);
        int pulses;
        pulses = 0;
        @(negedge clk);
        req[k] = 1'b1; we[k] = 1'b1; addr[k] = BASE + 32'hC; wdata[k] = 32'h55; strb[k] = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        req[k] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ready[k]) pulses++;
        end
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < NDUT; j++)
            check_eq(j, "rdata_after_reset", rdata[j], 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ready[k]) pulses++;
        end
        check_eq(k, "abort_no_ready", 32'(pulses), 32'd0);
`ifdef DBUS_INIT_CLEAR_EN
        repeat (DEPTH + 4) @(negedge clk);
`endif
        do_op(k, 1'b0, BASE + 32'hC, 32'd0, 4'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          sel;
        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; strb[k] = 4'h0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_eq(k, "reset_ready", {31'd0, ready[k]}, 32'd0);
            check_eq(k, "reset_err", {31'd0, err[k]}, 32'd0);
            check_eq(k, "reset_rdata", rdata[k], 32'd0);
        end
`ifdef DBUS_INIT_CLEAR_EN
        begin
            int c_ready;
            reset = 1'b0;
            req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE; strb[1] = 4'h0;
            c_ready = 0;
            for (int c = 1; c <= DEPTH + 64; c++) begin
                @(negedge clk);
                if (ready[1]) begin
                    c_ready = c;
                    break;
                end
            end
            req[1] = 1'b0;
            // the release cycle counts as cycle 1, so ready sits in cycle c+1
            check_eq(1, "init_ready_seen", {31'd0, c_ready != 0}, 32'd1);
            check_eq(1, "init_first_ready", {31'd0, (c_ready + 1) >= DEPTH + 2}, 32'd1);
            check_eq(1, "init_rdata", rdata[1], 32'd0);
            repeat (4) @(negedge clk);
        end
`else
        reset = 1'b0;
`endif

        // give the first 16 words known contents
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 16; i++)
                do_op(k, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);

        for (int k = 0; k < NDUT; k++) begin
            do_op(k, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
            do_op(k, 1'b0, 32'h1000_0004, 32'd0, 4'h0);
            check_eq(k, "deadbeef", rdata[k], 32'hDEAD_BEEF);
            do_op(k, 1'b1, 32'h1000_0008, 32'h1122_3344, 4'hF);
            do_op(k, 1'b1, 32'h1000_0008, 32'hAABB_CCDD, 4'b0100);
            do_op(k, 1'b0, 32'h1000_0008, 32'd0, 4'h0);
            check_eq(k, "byte_lane", rdata[k], 32'h11BB_3344);
            do_op(k, 1'b1, 32'h1000_0008, 32'hFFFF_FFFF, 4'h0);
            do_op(k, 1'b0, 32'h1000_000A, 32'd0, 4'hF);
            check_eq(k, "strb0_noop", rdata[k], 32'h11BB_3344);
            do_op(k, 1'b0, 32'h2000_0000, 32'd0, 4'hF);
            do_op(k, 1'b1, 32'h1000_0400, 32'hCAFE_F00D, 4'hF);
            do_op(k, 1'b0, 32'h1000_0000, 32'd0, 4'h0);
            b2b(k, $urandom);
        end

        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 40; n++) begin
                sel = int'($urandom_range(0, 9));
                d   = $urandom;
                s   = 4'($urandom_range(0, 15));
                if (sel < 7) begin
                    a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                end else if (sel == 7) begin
                    a = $urandom;
                    if (a[31:28] == 4'h1) a[31] = 1'b1;
                end else begin
                    a = BASE + 32'h400 + ($urandom_range(0, 255) << 2);
                end
                do_op(k, 1'($urandom_range(0, 1)), a, d, s);
            end
        end

        abort_write(0);
        abort_write(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
